// File: rtl/inst_cache.sv
// Direct-mapped instruction cache for the IF stage: one-cycle registered lookup,
// single-word fills with same-cycle write bypass, one-cycle flush of all lines.
module inst_cache #(
    parameter int unsigned INDEX_W = 7,
    parameter int unsigned ADDR_W  = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        read_i,
    input  logic [31:0] read_addr_i,
    input  logic        write_i,
    input  logic [31:0] write_addr_i,
    input  logic [31:0] write_inst_i,
    input  logic        flush_i,
    output logic        read_hit_o,
    output logic [31:0] read_inst_o
);

    localparam int unsigned LINES = 2 ** INDEX_W;
    localparam int unsigned TAG_W = ADDR_W - INDEX_W - 2;

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES];

    logic [INDEX_W-1:0] rd_idx, wr_idx;
    logic [TAG_W-1:0]   rd_tag, wr_tag;
    logic               look_hit;
    logic [31:0]        look_inst;
    logic               fill_en;

    assign rd_idx  = read_addr_i[INDEX_W+1:2];
    assign wr_idx  = write_addr_i[INDEX_W+1:2];
    assign rd_tag  = read_addr_i[ADDR_W-1:INDEX_W+2];
    assign wr_tag  = write_addr_i[ADDR_W-1:INDEX_W+2];
    assign fill_en = rdy & ~flush_i & write_i;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{read_addr_i[31:ADDR_W], read_addr_i[1:0],
                                write_addr_i[31:ADDR_W], write_addr_i[1:0]};

    // A lookup sees the line as it will be after this edge's fill.
    always_comb begin
        look_hit  = 1'b0;
        look_inst = data_mem[rd_idx];
        if (write_i && (wr_idx == rd_idx)) begin
            look_hit  = (wr_tag == rd_tag);
            look_inst = write_inst_i;
        end else begin
            look_hit  = valid[rd_idx] && (tag_mem[rd_idx] == rd_tag);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && fill_en) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= write_inst_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid       <= '0;
            read_hit_o  <= 1'b0;
            read_inst_o <= '0;
        end else if (rdy) begin
            if (flush_i) begin
                valid      <= '0;
                read_hit_o <= 1'b0;
                if (read_i) begin
                    read_inst_o <= '0;
                end
            end else begin
                if (write_i) begin
                    valid[wr_idx] <= 1'b1;
                end
                if (read_i) begin
                    read_hit_o  <= look_hit;
                    read_inst_o <= look_hit ? look_inst : '0;
                end else begin
                    read_hit_o <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_cache.sv
// Scoreboard bench for inst_cache: each step queues the expected registered
// output, clocks once, then pops and compares against the DUT.
module tb_inst_cache;

    typedef struct packed {
        logic        hit;
        logic [31:0] inst;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        read_i = 1'b0;
    logic [31:0] read_addr_i = '0;
    logic        write_i = 1'b0;
    logic [31:0] write_addr_i = '0;
    logic [31:0] write_inst_i = '0;
    logic        flush_i = 1'b0;
    logic        read_hit_o;
    logic [31:0] read_inst_o;

    exp_t sb[$];
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    inst_cache #(.INDEX_W(7), .ADDR_W(17)) dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .read_i      (read_i),
        .read_addr_i (read_addr_i),
        .write_i     (write_i),
        .write_addr_i(write_addr_i),
        .write_inst_i(write_inst_i),
        .flush_i     (flush_i),
        .read_hit_o  (read_hit_o),
        .read_inst_o (read_inst_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [32:0] got, input logic [32:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got hit=%0b inst=%08h, expected hit=%0b inst=%08h",
                     tag, got[32], got[31:0], exp[32], exp[31:0]);
        end
    endtask

    // Drive one cycle of stimulus, queue the expected result, clock, then compare.
    task automatic step(input string tag,
                        input logic r, input logic [31:0] ra,
                        input logic w, input logic [31:0] wa, input logic [31:0] wd,
                        input logic fl, input logic rd_v, input logic rs,
                        input logic eh, input logic [31:0] ei);
        exp_t e;
        exp_t got;
        read_i       = r;
        read_addr_i  = ra;
        write_i      = w;
        write_addr_i = wa;
        write_inst_i = wd;
        flush_i      = fl;
        rdy          = rd_v;
        rst          = rs;
        e.hit  = eh;
        e.inst = ei;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            got.hit  = read_hit_o;
            got.inst = read_inst_o;
            check_eq(tag, got, e);
        end
        read_i  = 1'b0;
        write_i = 1'b0;
        flush_i = 1'b0;
        rdy     = 1'b1;
        rst     = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic eh, input logic [31:0] ei);
        step(tag, 1'b1, a, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, eh, ei);
    endtask

    task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [31:0] held);
        step(tag, 1'b0, '0, 1'b1, a, d, 1'b0, 1'b1, 1'b0, 1'b0, held);
    endtask

    initial begin
        logic [31:0] faddr [5];
        faddr[0] = 32'h40; faddr[1] = 32'h44; faddr[2] = 32'h48;
        faddr[3] = 32'h4C; faddr[4] = 32'h20;

        step("reset", 1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);

        rd("cold_miss", 32'h4, 1'b0, 32'h0);
        wr("fill_4", 32'h4, 32'h0050_0093, 32'h0);
        rd("hit_4", 32'h4, 1'b1, 32'h0050_0093);
        step("idle_hold", 1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0050_0093);
        rd("ignore_low_bits", 32'h7, 1'b1, 32'h0050_0093);
        rd("ignore_high_bits", 32'hFFFE_0004, 1'b1, 32'h0050_0093);

        wr("fill_4_b", 32'h4, 32'h1111_1111, 32'h0050_0093);
        wr("fill_204", 32'h204, 32'h2222_2222, 32'h0050_0093);
        rd("evicted_4", 32'h4, 1'b0, 32'h0);
        rd("hit_204", 32'h204, 1'b1, 32'h2222_2222);

        step("bypass_same_tag", 1'b1, 32'h10, 1'b1, 32'h10, 32'hDEAD_BEEF,
             1'b0, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF);
        step("bypass_diff_tag", 1'b1, 32'h210, 1'b1, 32'h10, 32'hDEAD_BEEF,
             1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        step("diff_index_rw", 1'b1, 32'h204, 1'b1, 32'h8, 32'h3333_3333,
             1'b0, 1'b1, 1'b0, 1'b1, 32'h2222_2222);
        rd("hit_8", 32'h8, 1'b1, 32'h3333_3333);

        for (int unsigned i = 0; i < 4; i++)
            wr("flush_prefill", faddr[i], 32'hA000_0000 + i, 32'h3333_3333);
        step("flush_rw", 1'b1, 32'h40, 1'b1, 32'h20, 32'h5555_5555,
             1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        for (int unsigned i = 0; i < 5; i++)
            rd("after_flush", faddr[i], 1'b0, 32'h0);

        for (int unsigned i = 0; i < 4; i++)
            wr("rst_prefill", faddr[i], 32'hB000_0000 + i, 32'h0);
        rd("pre_rst_hit", 32'h40, 1'b1, 32'hB000_0000);
        step("rst_rw", 1'b1, 32'h44, 1'b1, 32'h20, 32'h6666_6666,
             1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        for (int unsigned i = 0; i < 5; i++)
            rd("after_rst", faddr[i], 1'b0, 32'h0);

        wr("stall_fill", 32'h4, 32'h0050_0093, 32'h0);
        rd("stall_pre_hit", 32'h4, 1'b1, 32'h0050_0093);
        step("stall_hold0", 1'b0, '0, 1'b1, 32'h4, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0050_0093);
        step("stall_hold1", 1'b1, 32'h8, 1'b1, 32'h4, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0050_0093);
        step("stall_hold2", 1'b1, 32'h4, 1'b1, 32'h4, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0050_0093);
        rd("stall_post_hit", 32'h4, 1'b1, 32'h0050_0093);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
